uart_index_assembler: RTL and testbench



---
 rtl/uart_index_assembler_pkg.sv | 19 +
 rtl/uart_index_assembler_interbyte_timer.sv | 30 +++
 rtl/uart_index_assembler.sv | 140 ++++++++++++++
 tb/tb_uart_index_assembler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_index_assembler_pkg.sv
// Shared constants, state encoding and helpers for the UART sine-index frame assembler.
package uart_index_assembler_pkg;

   localparam logic [3:0] BROADCAST_ID           = 4'hF;
   localparam logic [1:0] ERR_PARITY             = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT            = 2'b10;
   localparam logic [1:0] ERR_ID                 = 2'b11;
   localparam int         DEFAULT_TIMEOUT_CYCLES = 2400;

   typedef enum logic {
      WAIT_HI = 1'b0,
      WAIT_LO = 1'b1
   } state_t;

   function automatic logic id_accept(input logic [3:0] id, input logic [3:0] module_id);
      return (id == module_id) || (id == BROADCAST_ID);
   endfunction

endpackage

// File: rtl/uart_index_assembler_interbyte_timer.sv
// Clearable up-counter that flags expiry once it has counted TIMEOUT_CYCLES-1 enabled cycles.
module uart_index_assembler_interbyte_timer
   import uart_index_assembler_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_en,
   output logic o_expire
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expire = i_en && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_index_assembler.sv
// Rebuilds 12-bit sine indices from two-byte UART frames with timeout and parity handling.
// Optional ID filtering is enabled by defining INDEX_ID_FILTER_EN.
module uart_index_assembler
   import uart_index_assembler_pkg::*;
#(
   parameter logic [3:0] MODULE_ID      = 4'h1,
   parameter int         TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int         ERR_CNT_W      = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           data_received,
   input  logic                 rx_done,
   input  logic                 parity_error,
   output logic [11:0]          sin_index,
   output logic [3:0]           frame_id,
   output logic                 index_valid,
   output logic                 frame_error,
   output logic [1:0]           error_code,
   output logic [ERR_CNT_W-1:0] err_count
);

`ifdef INDEX_ID_FILTER_EN
   localparam bit ID_FILTER_ON = 1'b1;
`else
   localparam bit ID_FILTER_ON = 1'b0;
`endif

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic                 r_rx_d;
   logic                 r_evt;
   logic [7:0]           r_data;
   logic                 r_par;
   state_t               r_state;
   logic [3:0]           r_id;
   logic [3:0]           r_hi;
   logic [11:0]          r_sin_index;
   logic [3:0]           r_frame_id;
   logic                 r_index_valid;
   logic                 r_frame_error;
   logic [1:0]           r_error_code;
   logic [ERR_CNT_W-1:0] r_err_count;
   logic                 w_expire;
   logic                 w_accept;

   // Edge-detect stage: one event per received byte, data captured alongside.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_d <= 1'b0;
         r_evt  <= 1'b0;
         r_data <= '0;
         r_par  <= 1'b0;
      end else begin
         r_rx_d <= rx_done;
         r_evt  <= rx_done & ~r_rx_d;
         r_data <= data_received;
         r_par  <= parity_error;
      end
   end

   uart_index_assembler_interbyte_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .i_clear (r_state == WAIT_HI),
      .i_en    (r_state == WAIT_LO),
      .o_expire(w_expire)
   );

   assign w_accept = !ID_FILTER_ON || id_accept(r_id, MODULE_ID);

   // Frame FSM with registered outputs; a byte event takes priority over timer expiry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= WAIT_HI;
         r_id          <= '0;
         r_hi          <= '0;
         r_sin_index   <= '0;
         r_frame_id    <= '0;
         r_index_valid <= 1'b0;
         r_frame_error <= 1'b0;
         r_error_code  <= '0;
         r_err_count   <= '0;
      end else begin
         r_index_valid <= 1'b0;
         r_frame_error <= 1'b0;
         case (r_state)
            WAIT_HI: begin
               if (r_evt) begin
                  if (r_par) begin
                     r_frame_error <= 1'b1;
                     r_error_code  <= ERR_PARITY;
                     r_err_count   <= sat_inc(r_err_count);
                  end else begin
                     r_id    <= r_data[7:4];
                     r_hi    <= r_data[3:0];
                     r_state <= WAIT_LO;
                  end
               end
            end
            WAIT_LO: begin
               if (r_evt) begin
                  r_state <= WAIT_HI;
                  if (r_par) begin
                     r_frame_error <= 1'b1;
                     r_error_code  <= ERR_PARITY;
                     r_err_count   <= sat_inc(r_err_count);
                  end else if (w_accept) begin
                     r_sin_index   <= {r_hi, r_data};
                     r_frame_id    <= r_id;
                     r_index_valid <= 1'b1;
                  end else begin
                     r_frame_error <= 1'b1;
                     r_error_code  <= ERR_ID;
                     r_err_count   <= sat_inc(r_err_count);
                  end
               end else if (w_expire) begin
                  r_state       <= WAIT_HI;
                  r_frame_error <= 1'b1;
                  r_error_code  <= ERR_TIMEOUT;
                  r_err_count   <= sat_inc(r_err_count);
               end
            end
            default: r_state <= WAIT_HI;
         endcase
      end
   end

   assign sin_index   = r_sin_index;
   assign frame_id    = r_frame_id;
   assign index_valid = r_index_valid;
   assign frame_error = r_frame_error;
   assign error_code  = r_error_code;
   assign err_count   = r_err_count;

endmodule

// File: tb/tb_uart_index_assembler.sv
// Self-checking bench for uart_index_assembler: directed and random byte streams against a frame-level model.
module tb_uart_index_assembler;

   localparam int         TO  = 2400;
   localparam logic [3:0] MID = 4'h1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  data_received = '0;
   logic        rx_done = 1'b0;
   logic        parity_error = 1'b0;
   logic [11:0] sin_index;
   logic [3:0]  frame_id;
   logic        index_valid;
   logic        frame_error;
   logic [1:0]  error_code;
   logic [7:0]  err_count;

   uart_index_assembler #(
      .MODULE_ID     (MID),
      .TIMEOUT_CYCLES(TO),
      .ERR_CNT_W     (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .data_received(data_received),
      .rx_done      (rx_done),
      .parity_error (parity_error),
      .sin_index    (sin_index),
      .frame_id     (frame_id),
      .index_valid  (index_valid),
      .frame_error  (frame_error),
      .error_code   (error_code),
      .err_count    (err_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      int         stamp;
      int         kind;   // 1 = index accepted, 2 = frame discarded
      logic [11:0] idx;
      logic [3:0]  id;
      logic [1:0]  code;
      int         ecnt;
   } ev_t;

   ev_t exp_q[$];
   ev_t obs_q[$];

   // Frame-level reference state
   bit         m_pend = 0;
   int         m_c1 = 0;
   logic [3:0] m_id = '0, m_hi = '0;
   logic [11:0] m_idx = '0;
   logic [3:0] m_fid = '0;
   logic [1:0] m_code = '0;
   int         m_ecnt = 0;

   function automatic bit filter_pass(input logic [3:0] id);
`ifdef INDEX_ID_FILTER_EN
      return (id == MID) || (id == 4'hF);
`else
      return 1'b1;
`endif
   endfunction

   task automatic push_err(input int stamp, input logic [1:0] code);
      ev_t e;
      m_ecnt = (m_ecnt < 255) ? m_ecnt + 1 : 255;
      m_code = code;
      e = '{stamp, 2, m_idx, m_fid, code, m_ecnt};
      exp_q.push_back(e);
   endtask

   task automatic push_valid(input int stamp);
      ev_t e;
      e = '{stamp, 1, m_idx, m_fid, m_code, m_ecnt};
      exp_q.push_back(e);
   endtask

   // A pending first byte times out when no second byte is seen within TO cycles of it.
   task automatic model_timeout(input int now_c);
      if (m_pend && (now_c - m_c1 > TO)) begin
         push_err(m_c1 + 1 + TO, 2'b10);
         m_pend = 0;
      end
   endtask

   task automatic model_byte(input int c, input logic [7:0] d, input logic p);
      model_timeout(c);
      if (!m_pend) begin
         if (p) push_err(c + 1, 2'b01);
         else begin
            m_pend = 1; m_c1 = c; m_id = d[7:4]; m_hi = d[3:0];
         end
      end else begin
         m_pend = 0;
         if (p) push_err(c + 1, 2'b01);
         else if (!filter_pass(m_id)) push_err(c + 1, 2'b11);
         else begin
            m_idx = {m_hi, d}; m_fid = m_id;
            push_valid(c + 1);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!reset && (index_valid || frame_error)) begin
         ev_t e;
         check("exclusive_strobes", {31'd0, index_valid & frame_error}, 32'd0);
         e = '{cyc, index_valid ? 1 : 2, sin_index, frame_id, error_code, int'(err_count)};
         obs_q.push_back(e);
      end
   end

   // Called right after a negedge; rx_done first sampled on the next posedge.
   task automatic send_byte(input logic [7:0] d, input logic p, input int hold, input int gap);
      rx_done = 1'b1; data_received = d; parity_error = p;
      model_byte(cyc + 1, d, p);
      repeat (hold) @(negedge clk);
      rx_done = 1'b0; data_received = 8'($urandom); parity_error = 1'($urandom);
      repeat (gap) @(negedge clk);
   endtask

   task automatic compare(input string ph);
      int n;
      repeat (4) @(negedge clk);
      model_timeout(cyc);
      check({ph, ".n_events"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s.ev%0d.stamp", ph, i), obs_q[i].stamp, exp_q[i].stamp);
         check($sformatf("%s.ev%0d.kind", ph, i), obs_q[i].kind, exp_q[i].kind);
         check($sformatf("%s.ev%0d.idx", ph, i), obs_q[i].idx, exp_q[i].idx);
         check($sformatf("%s.ev%0d.id", ph, i), obs_q[i].id, exp_q[i].id);
         check($sformatf("%s.ev%0d.code", ph, i), obs_q[i].code, exp_q[i].code);
         check($sformatf("%s.ev%0d.ecnt", ph, i), obs_q[i].ecnt, exp_q[i].ecnt);
      end
      check({ph, ".sin_index"}, sin_index, m_idx);
      check({ph, ".frame_id"}, frame_id, m_fid);
      check({ph, ".error_code"}, error_code, m_code);
      check({ph, ".err_count"}, err_count, m_ecnt);
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic do_reset(input string ph);
      reset = 1'b1; rx_done = 1'b0; parity_error = 1'b0;
      repeat (2) @(negedge clk);
      check({ph, ".rst.sin_index"}, sin_index, 0);
      check({ph, ".rst.frame_id"}, frame_id, 0);
      check({ph, ".rst.index_valid"}, index_valid, 0);
      check({ph, ".rst.frame_error"}, frame_error, 0);
      check({ph, ".rst.error_code"}, error_code, 0);
      check({ph, ".rst.err_count"}, err_count, 0);
      reset = 1'b0;
      m_pend = 0; m_idx = '0; m_fid = '0; m_code = '0; m_ecnt = 0;
      obs_q.delete();
      exp_q.delete();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      do_reset("init");

      send_byte(8'h1A, 0, 1, 1000);
      send_byte(8'h5C, 0, 1, 10);
      compare("basic");

      send_byte(8'h13, 0, 1, TO + 10);
      send_byte(8'h1F, 0, 1, 5);
      send_byte(8'hFF, 0, 1, 5);
      compare("timeout");

      send_byte(8'h12, 0, 1, 5);
      send_byte(8'h34, 1, 1, 5);
      compare("parity");

      send_byte(8'h27, 0, 1, 5);
      send_byte(8'h00, 0, 1, 5);
      send_byte(8'hF7, 0, 1, 5);
      send_byte(8'h00, 0, 1, 5);
      compare("idfilter");

      // Second byte lands exactly on the expiry cycle, then one cycle too late.
      send_byte(8'h1A, 0, 5, TO - 5);
      send_byte(8'hB3, 0, 5, 10);
      send_byte(8'h21, 0, 5, TO - 4);
      send_byte(8'h22, 0, 5, 3);
      send_byte(8'h33, 0, 1, 3);
      compare("level_edge");

      for (int i = 0; i < 160; i++) begin
         logic [7:0] d;
         int sel;
         d = 8'($urandom);
         sel = $urandom_range(0, 2);
         if (sel == 0) d[7:4] = MID;
         else if (sel == 1) d[7:4] = 4'hF;
         send_byte(d, ($urandom_range(0, 9) == 0), $urandom_range(1, 4),
                   ($urandom_range(0, 59) == 0) ? TO + 5 : $urandom_range(1, 12));
      end
      compare("random");

      do_reset("presat");
      for (int i = 0; i < 300; i++) send_byte(8'($urandom), 1, 1, 1);
      compare("saturate");

      send_byte(8'h1A, 0, 1, 3);
      do_reset("midframe");
      send_byte(8'h2B, 0, 1, 3);
      send_byte(8'hCD, 0, 1, 3);
      send_byte(8'h1E, 0, 1, 3);
      send_byte(8'h42, 0, 1, 3);
      compare("after_reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
